// File: rtl/code_len_expander.sv
// Expands the DEFLATE code-length symbol stream (literals 0..15, repeats 16/17/18)
// into a flat table of code lengths written one entry per cycle into the buffer memory.
module code_len_expander #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] code_num,
  input  logic              sym_vld,
  input  logic [LEN_W-1:0]  sym,
  output logic              sym_rdy,
  output logic              ext_req,
  output logic [2:0]        ext_len,
  input  logic              ext_vld,
  input  logic [6:0]        ext_data,
  output logic              buf_winc,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [LEN_W-1:0]  buf_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_SYM, S_EXT, S_FILL, S_ERR} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_code_num;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [LEN_W-1:0]  r_prev_len;
  logic              r_have_prev;
  logic [LEN_W-1:0]  r_val;
  logic [ADDR_W:0]   r_run;
  logic              r_sym_rdy;
  logic              r_ext_req;
  logic [2:0]        r_ext_len;
  logic              r_buf_winc;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [LEN_W-1:0]  r_buf_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [ADDR_W:0]   w_run;
  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W:0]   w_wr_nxt;

  // Run length of the pending repeat; the requested extra-bit count identifies the repeat code.
  always_comb begin
    w_run = '0;
    case (r_ext_len)
      3'd2:    w_run = (ADDR_W+1)'(ext_data[1:0]) + (ADDR_W+1)'(3);
      3'd3:    w_run = (ADDR_W+1)'(ext_data[2:0]) + (ADDR_W+1)'(3);
      3'd7:    w_run = (ADDR_W+1)'(ext_data[6:0]) + (ADDR_W+1)'(11);
      default: w_run = '0;
    endcase
  end

  assign w_sum    = {1'b0, r_wr_cnt} + w_run;
  assign w_wr_nxt = {1'b0, r_wr_cnt} + (ADDR_W+1)'(1);

  // Control FSM with all outputs registered; write pulses and done default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_code_num  <= '0;
      r_wr_cnt    <= '0;
      r_prev_len  <= '0;
      r_have_prev <= 1'b0;
      r_val       <= '0;
      r_run       <= '0;
      r_sym_rdy   <= 1'b0;
      r_ext_req   <= 1'b0;
      r_ext_len   <= 3'd0;
      r_buf_winc  <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_buf_winc <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE, S_ERR: begin
          if (start) begin
            r_code_num  <= code_num;
            r_wr_cnt    <= '0;
            r_prev_len  <= '0;
            r_have_prev <= 1'b0;
            r_err       <= 1'b0;
            if (code_num == '0) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_busy    <= 1'b1;
              r_sym_rdy <= 1'b1;
              r_state   <= S_SYM;
            end
          end
        end
        S_SYM: begin
          if (r_wr_cnt == r_code_num) begin
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_sym_rdy <= 1'b0;
            r_state   <= S_IDLE;
          end else if (sym_vld && r_sym_rdy) begin
            if (sym < LEN_W'(16)) begin
              r_buf_winc  <= 1'b1;
              r_buf_addr  <= r_wr_cnt;
              r_buf_data  <= sym;
              r_wr_cnt    <= w_wr_nxt[ADDR_W-1:0];
              r_prev_len  <= sym;
              r_have_prev <= 1'b1;
              r_sym_rdy   <= (w_wr_nxt < {1'b0, r_code_num});
            end else if (sym == LEN_W'(16) && r_have_prev) begin
              r_val     <= r_prev_len;
              r_ext_len <= 3'd2;
              r_ext_req <= 1'b1;
              r_sym_rdy <= 1'b0;
              r_state   <= S_EXT;
            end else if (sym == LEN_W'(17) || sym == LEN_W'(18)) begin
              r_val      <= '0;
              r_prev_len <= '0;
              r_ext_len  <= (sym == LEN_W'(17)) ? 3'd3 : 3'd7;
              r_ext_req  <= 1'b1;
              r_sym_rdy  <= 1'b0;
              r_state    <= S_EXT;
            end else begin
              r_err     <= 1'b1;
              r_busy    <= 1'b0;
              r_sym_rdy <= 1'b0;
              r_state   <= S_ERR;
            end
          end
        end
        S_EXT: begin
          if (ext_vld) begin
            r_ext_req <= 1'b0;
            r_ext_len <= 3'd0;
            // An overflowing run is rejected whole, before any entry of it is written.
            if (w_sum > {1'b0, r_code_num}) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_ERR;
            end else begin
              r_buf_winc <= 1'b1;
              r_buf_addr <= r_wr_cnt;
              r_buf_data <= r_val;
              r_wr_cnt   <= w_wr_nxt[ADDR_W-1:0];
              r_run      <= w_run - (ADDR_W+1)'(1);
              r_state    <= S_FILL;
            end
          end
        end
        S_FILL: begin
          r_buf_winc <= 1'b1;
          r_buf_addr <= r_wr_cnt;
          r_buf_data <= r_val;
          r_wr_cnt   <= w_wr_nxt[ADDR_W-1:0];
          r_run      <= r_run - (ADDR_W+1)'(1);
          if (r_run == (ADDR_W+1)'(1)) begin
            r_sym_rdy <= (w_wr_nxt < {1'b0, r_code_num});
            r_state   <= S_SYM;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sym_rdy  = r_sym_rdy;
  assign ext_req  = r_ext_req;
  assign ext_len  = r_ext_len;
  assign buf_winc = r_buf_winc;
  assign buf_addr = r_buf_addr;
  assign buf_data = r_buf_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule
